// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and defaults for the adder sum accumulator
package adder_pkg;

    localparam int ADDER_WIDTH = 32;
    localparam int ACC_COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_e;

    typedef struct packed {
        logic        carry;
        logic [31:0] sum;
    } acc_beat_t;

endpackage

// File: rtl/acc_frame_ctrl.sv
// rtl/acc_frame_ctrl.sv - frame FSM, frame-length compare and handshake outputs
module acc_frame_ctrl
    import adder_pkg::*;
#(
    parameter int COUNT_W = ACC_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] frame_len,
    input  logic               in_valid,
    input  logic               out_ready,
    input  logic [COUNT_W-1:0] beat_cnt,
    output logic               in_ready,
    output logic               out_valid,
    output logic               busy,
    output logic               start_ok,
    output logic               xfer
);

    acc_state_e         state;
    acc_state_e         state_next;
    logic [COUNT_W-1:0] len_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            len_q <= '0;
        end else begin
            state <= state_next;
            if (start_ok) begin
                len_q <= frame_len;
            end
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        start_ok   = 1'b0;
        xfer       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    state_next = (frame_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                xfer     = in_valid;
                // The beat landing on this edge is the last one when the count reaches len_q.
                if (in_valid && (beat_cnt + COUNT_W'(1) == len_q)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/adder_sum_accumulator.sv
// rtl/adder_sum_accumulator.sv - accumulates framed {carry,sum} beats from the adder
// Optional carry-beat counter enabled by defining ACC_CARRY_CNT_EN.
module adder_sum_accumulator
    import adder_pkg::*;
#(
    parameter  int WIDTH   = ADDER_WIDTH,
    parameter  int COUNT_W = ACC_COUNT_W,
    localparam int ACC_W   = WIDTH + 1 + COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] frame_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   sum_in,
    input  logic               carry_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   acc_out,
    output logic [COUNT_W-1:0] beat_cnt,
    output logic               busy,
    output logic [COUNT_W-1:0] carry_cnt
);

    logic             start_ok;
    logic             xfer;
    logic [ACC_W-1:0] acc;
    logic [WIDTH:0]   beat;

    assign beat    = {carry_in, sum_in};
    assign acc_out = acc;

    acc_frame_ctrl #(
        .COUNT_W(COUNT_W)
    ) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .frame_len(frame_len),
        .in_valid (in_valid),
        .out_ready(out_ready),
        .beat_cnt (beat_cnt),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .busy     (busy),
        .start_ok (start_ok),
        .xfer     (xfer)
    );

    // ACC_W leaves COUNT_W bits of headroom, so the sum cannot wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (start_ok) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else if (xfer) begin
            acc      <= acc + ACC_W'(beat);
            beat_cnt <= beat_cnt + COUNT_W'(1);
        end
    end

`ifdef ACC_CARRY_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (start_ok) begin
            carry_cnt <= '0;
        end else if (xfer && carry_in) begin
            carry_cnt <= carry_cnt + COUNT_W'(1);
        end
    end
`else
    assign carry_cnt = '0;
`endif

endmodule
